// File: rtl/filter_load_ctrl.sv
// rtl/filter_load_ctrl.sv - loads a 4x4 byte filter row-by-row from memory, then streams its elements for N scans
module filter_load_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_scans,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic              fb_ld,
  output logic [1:0]        fb_row,
  output logic [1:0]        fb_col,
  output logic [31:0]       fb_data,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic              elem_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, SCAN, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        nscan_q;
  logic [7:0]        scan_cnt;
  logic [7:0]        scan_inc;
  logic [1:0]        row;
  logic [1:0]        col;
  logic              at_last;

  assign scan_inc = scan_cnt + 8'd1;
  assign at_last  = (row == 2'd3) && (col == 2'd3);

  // row doubles as the fetch row counter; it wraps 3->0 on the last load so
  // SCAN starts at element (0,0) without an explicit clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      base_q   <= '0;
      nscan_q  <= '0;
      scan_cnt <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            nscan_q  <= num_scans;
            scan_cnt <= '0;
            row      <= '0;
            col      <= '0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            row <= row + 2'd1;
            col <= '0;
          end
        end
        SCAN: begin
          if (elem_ready) begin
            col <= col + 2'd1;
            if (col == 2'd3) row <= row + 2'd1;
            if (at_last) scan_cnt <= scan_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    mem_req    = 1'b0;
    mem_addr   = '0;
    fb_ld      = 1'b0;
    fb_row     = '0;
    fb_col     = '0;
    fb_data    = '0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = base_q + ADDR_W'(row);
        fb_ld    = mem_ack;
        fb_data  = mem_data;
        fb_row   = row;
        if (mem_ack && row == 2'd3) state_nx = (nscan_q == 8'd0) ? DONE : SCAN;
      end
      SCAN: begin
        elem_valid = 1'b1;
        fb_row     = row;
        fb_col     = col;
        elem_last  = at_last;
        if (elem_ready && at_last && scan_inc == nscan_q) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_filter_load_ctrl.sv
// tb/tb_filter_load_ctrl.sv - directed self-checking bench for filter_load_ctrl
module tb_filter_load_ctrl;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        num_scans;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_data;
  logic              fb_ld;
  logic [1:0]        fb_row;
  logic [1:0]        fb_col;
  logic [31:0]       fb_data;
  logic              elem_valid;
  logic              elem_ready;
  logic              elem_last;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;

  filter_load_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_scans(num_scans),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .fb_ld(fb_ld), .fb_row(fb_row), .fb_col(fb_col), .fb_data(fb_data),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_last(elem_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [88:0] all_out();
    return {mem_req, mem_addr, fb_ld, fb_row, fb_col, fb_data, elem_valid, elem_last, busy, done};
  endfunction

  task automatic issue_start(input logic [ADDR_W-1:0] b, input logic [7:0] n);
    start = 1'b1; base_addr = b; num_scans = n;
    next_cycle();
    start = 1'b0; base_addr = '0; num_scans = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; mem_ack = 1'b1; elem_ready = 1'b1;
    base_addr = 16'h1234; num_scans = 8'd3; mem_data = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      tests++;
      if (all_out() !== '0) begin fails++; $display("FAIL reset_outs cycle %0d: got %h want 0", i, all_out()); end
    end
    rst = 1'b1; start = 1'b0; base_addr = '0; num_scans = '0; mem_data = '0;
    next_cycle(); #1;
    tests++;
    if (all_out() !== '0) begin fails++; $display("FAIL post_reset_idle: got %h want 0", all_out()); end
  endtask

  task automatic test_basic();
    mem_ack = 1'b1; elem_ready = 1'b1;
    issue_start(16'h0010, 8'd1);
    for (int k = 0; k < 4; k++) begin
      mem_data = 32'hA0B0C000 + 32'(k); #1;
      tests++;
      if ({mem_req, mem_addr, fb_ld, fb_row, fb_data, elem_valid, busy} !==
          {1'b1, 16'h0010 + 16'(k), 1'b1, 2'(k), 32'hA0B0C000 + 32'(k), 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL basic_fetch row %0d: req=%b addr=%h ld=%b row=%0d data=%h ev=%b busy=%b",
                 k, mem_req, mem_addr, fb_ld, fb_row, fb_data, elem_valid, busy);
      end
      next_cycle();
    end
    mem_data = '0;
    for (int e = 0; e < 16; e++) begin
      #1;
      tests++;
      if ({elem_valid, fb_row, fb_col, elem_last, fb_ld, mem_req, busy, done} !==
          {1'b1, 2'(e / 4), 2'(e % 4), (e == 15), 1'b0, 1'b0, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL basic_scan elem %0d: ev=%b row=%0d col=%0d last=%b ld=%b req=%b", e,
                 elem_valid, fb_row, fb_col, elem_last, fb_ld, mem_req);
      end
      next_cycle();
    end
    #1;
    tests++;
    if ({done, busy, elem_valid} !== 3'b110) begin
      fails++; $display("FAIL basic_done_cycle21: done=%b busy=%b ev=%b want 1 1 0", done, busy, elem_valid);
    end
    next_cycle(); #1;
    tests++;
    if (all_out() !== '0) begin fails++; $display("FAIL basic_after_done: got %h want 0", all_out()); end
  endtask

  task automatic test_ack_delay();
    int lds = 0;
    mem_ack = 1'b1; elem_ready = 1'b1;
    issue_start(16'h0010, 8'd0);
    #1; lds += int'(fb_ld);
    next_cycle();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({mem_req, mem_addr, fb_ld} !== {1'b1, 16'h0011, 1'b0}) begin
        fails++; $display("FAIL ack_wait %0d: req=%b addr=%h ld=%b want 1 0011 0", i, mem_req, mem_addr, fb_ld);
      end
      next_cycle();
    end
    mem_ack = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1; lds += int'(fb_ld);
      tests++;
      if ({mem_addr, fb_row} !== {16'h0010 + 16'(k), 2'(k)}) begin
        fails++; $display("FAIL ack_resume row %0d: addr=%h row=%0d", k, mem_addr, fb_row);
      end
      next_cycle();
    end
    #1;
    tests++;
    if (lds != 4 || done !== 1'b1) begin
      fails++; $display("FAIL ack_ld_count: loads=%0d done=%b want 4 1", lds, done);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    int e = 0, lasts = 0, dones = 0, cyc = 0;
    mem_ack = 1'b1; elem_ready = 1'b1;
    issue_start(16'h0100, 8'd2);
    for (int k = 0; k < 4; k++) next_cycle();
    while (cyc < 100) begin
      elem_ready = (cyc % 2 == 0); #1;
      if (done) break;
      tests++;
      if ({elem_valid, fb_row, fb_col, elem_last} !== {1'b1, 2'((e % 16) / 4), 2'(e % 4), (e % 16 == 15)}) begin
        fails++;
        $display("FAIL bp_elem %0d cyc %0d: ev=%b row=%0d col=%0d last=%b", e, cyc, elem_valid, fb_row, fb_col, elem_last);
      end
      if (elem_ready) begin
        e++;
        if (elem_last) lasts++;
      end
      cyc++;
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) #1;
      dones += int'(done);
      next_cycle();
    end
    tests++;
    if (e != 32 || lasts != 2 || dones != 1) begin
      fails++; $display("FAIL bp_totals: xfers=%0d lasts=%0d dones=%0d want 32 2 1", e, lasts, dones);
    end
    elem_ready = 1'b1;
  endtask

  task automatic test_zero_scans();
    int lds = 0, evs = 0;
    mem_ack = 1'b1; elem_ready = 1'b1;
    issue_start(16'h0040, 8'd0);
    for (int k = 0; k < 4; k++) begin
      #1; lds += int'(fb_ld); evs += int'(elem_valid);
      next_cycle();
    end
    #1;
    tests++;
    if (lds != 4 || evs != 0 || done !== 1'b1 || elem_valid !== 1'b0) begin
      fails++; $display("FAIL zero_scans: loads=%0d valids=%0d done=%b want 4 0 1", lds, evs, done);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
    mem_ack = 1'b1;
    issue_start(16'hFFFE, 8'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if (mem_addr !== exp_addr[k] || mem_req !== 1'b1) begin
        fails++; $display("FAIL wrap_addr %0d: got %h req=%b want %h", k, mem_addr, mem_req, exp_addr[k]);
      end
      next_cycle();
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_scan();
    mem_ack = 1'b1; elem_ready = 1'b1;
    issue_start(16'h0200, 8'd1);
    for (int k = 0; k < 4 + 9; k++) next_cycle();
    #1;
    tests++;
    if ({elem_valid, fb_row, fb_col} !== {1'b1, 2'd2, 2'd1}) begin
      fails++; $display("FAIL rst_pos: ev=%b row=%0d col=%0d want 1 2 1", elem_valid, fb_row, fb_col);
    end
    rst = 1'b0;
    next_cycle();
    rst = 1'b1; #1;
    tests++;
    if (all_out() !== '0) begin fails++; $display("FAIL rst_mid_scan_outs: got %h want 0", all_out()); end
    issue_start(16'h0300, 8'd0);
    start = 1'b1; base_addr = 16'h0900; num_scans = 8'd5;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if ({mem_addr, fb_row, fb_ld} !== {16'h0300 + 16'(k), 2'(k), 1'b1}) begin
        fails++; $display("FAIL reload row %0d: addr=%h row=%0d ld=%b", k, mem_addr, fb_row, fb_ld);
      end
      next_cycle();
    end
    #1;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL reload_done: got %b want 1", done); end
    start = 1'b0; base_addr = '0; num_scans = '0;
    next_cycle(); #1;
    tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL busy_start_ignored: busy=%b req=%b want 0 0", busy, mem_req);
    end
  endtask

  initial begin
    start = 1'b0; base_addr = '0; num_scans = '0; mem_ack = 1'b0; mem_data = '0; elem_ready = 1'b0; rst = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_ack_delay();
    test_backpressure();
    test_zero_scans();
    test_wrap();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filter_load_ctrl.md
FILTER_LOAD_CTRL -- requirements
Module: filter_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of memory word address.
REQ-002 SHALL have ports as follows, one per line:
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  synchronous, active-low reset.
  start  input  1  one-cycle request to load filter and run scans.
  base_addr  input  ADDR_W  word address of filter row 0.
  num_scans  input  8  number of full 4x4 element scans after load.
  mem_req  output  1  memory read request.
  mem_addr  output  ADDR_W  memory read word address.
  mem_ack  input  1  read data valid on mem_data this cycle.
  mem_data  input  32  read word, one filter row, byte 3 = column 0.
  fb_ld  output  1  filter buffer row load strobe.
  fb_row  output  2  filter buffer row select.
  fb_col  output  2  filter buffer column select.
  fb_data  output  32  filter buffer load data.
  elem_valid  output  1  current fb_row/fb_col element offered downstream.
  elem_ready  input  1  downstream accepts element.
  elem_last  output  1  offered element is row 3, col 3.
  busy  output  1  high in every state except IDLE.
  done  output  1  one-cycle completion pulse.

Function
REQ-003 SHALL implement states IDLE, FETCH, SCAN, DONE.
REQ-004 IDLE: start=1 SHALL latch base_addr and num_scans, clear row counter r=0, and enter FETCH next cycle; start in any other state SHALL be ignored.
REQ-005 FETCH: mem_req SHALL be 1 and mem_addr SHALL equal latched base + r, truncated to ADDR_W (wrap modulo 2^ADDR_W).
REQ-006 FETCH: mem_req and mem_addr SHALL hold stable until mem_ack=1; mem_ack outside FETCH SHALL be ignored.
REQ-007 FETCH: fb_ld SHALL equal mem_ack, fb_data SHALL equal mem_data combinationally, and fb_row SHALL equal r, so the row loads on the mem_ack edge.
REQ-008 On mem_ack with r<3, r SHALL increment and remain in FETCH; a new request SHALL be asserted on the following cycle, giving a minimum 1 cycle per row.
REQ-009 On mem_ack with r=3: if latched num_scans=0, SHALL enter DONE; otherwise SHALL enter SCAN with row=0, col=0, scan count=0.
REQ-010 SCAN: elem_valid SHALL be 1; fb_row/fb_col SHALL present the current element; fb_ld SHALL be 0.
REQ-011 SCAN: a transfer SHALL occur when elem_valid and elem_ready are both 1; without a transfer, indices SHALL hold.
REQ-012 On each transfer, col SHALL increment; when col is 3, col SHALL wrap to 0 and row SHALL increment, giving row-major order.
REQ-013 elem_last SHALL be 1 exactly when SCAN and row=3, col=3.
REQ-014 On a transfer with elem_last, scan count SHALL increment; if the new count equals num_scans, SHALL enter DONE; else row and col SHALL return to 0 and SCAN continues with no bubble.
REQ-015 DONE: done SHALL be 1 for exactly one cycle, then SHALL enter IDLE; start in the DONE cycle SHALL be ignored.
REQ-016 busy SHALL be 1 in FETCH, SCAN, and DONE.
REQ-017 Outside FETCH, mem_req and fb_ld SHALL be 0; outside SCAN, elem_valid and elem_last SHALL be 0.
REQ-018 Outside FETCH and SCAN, fb_row and fb_col SHALL be 0, and fb_data SHALL be 0 outside FETCH.
REQ-019 Latency: start at cycle N SHALL give mem_req=1 at cycle N+1; with mem_ack always 1 and elem_ready always 1, done SHALL pulse at cycle N+5+16*num_scans.

Reset
REQ-020 rst=0 at a rising edge SHALL force IDLE and clear all counters and latched values, in any state including mid-FETCH or mid-SCAN.
REQ-021 During and after reset, all outputs SHALL be 0 until the next start.
REQ-022 A mem_ack or elem_ready arriving in the reset cycle SHALL have no effect.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - base_addr=0x0010, num_scans=1, mem_ack always 1, elem_ready always 1 -> mem_addr 0x10..0x13 on consecutive cycles with fb_ld=1 and fb_row 0..3; then 16 elements in row-major order with elem_last on the 16th; done 21 cycles after start.
  - mem_ack delayed 3 cycles on row 1 -> mem_addr holds 0x11 with mem_req=1 and fb_ld=0 for 3 cycles; fb_ld pulses once per row.
  - num_scans=2, elem_ready toggling 1,0,1,0 -> indices hold on ready=0; 32 transfers; elem_last twice; single done pulse.
  - num_scans=0 -> 4 loads, no elem_valid, done pulse one cycle after the 4th mem_ack.
  - base_addr=0xFFFE with ADDR_W=16 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - rst=0 during SCAN at row 2 col 1 -> next cycle all outputs 0 and busy=0; then a start reloads from row 0; a start asserted while busy has no effect.
